// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with run/stop/clear/load control.
// Control comes from debounced button pulses and UART command bytes.
// Supports wrap or stop-at-limit, a decimal preset entered over UART,
// and a registered terminal-count pulse.
module updown_counter_param #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 9999,
    parameter int WRAP      = 1,
    localparam int WIDTH    = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_run_stop,
    input  logic             btn_clear,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] preset,
    output logic             mode,
    output logic [1:0]       led_mode,
    output logic [1:0]       led_run_stop,
    output logic             tc
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    DIV_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH+3:0] MAX_EXT  = (WIDTH + 4)'(MAX_COUNT);

    // Mode FSM encodings
    localparam logic [0:0] M_UP   = 1'b0;
    localparam logic [0:0] M_DOWN = 1'b1;

    // Run FSM encodings
    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_LOAD  = 2'd3;

    logic [0:0]       mode_q, mode_d;
    logic [1:0]       run_q, run_d;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] preset_d;

    logic cmd_m, cmd_u, cmd_d, cmd_r, cmd_s, cmd_c, cmd_l, cmd_digit;
    logic [3:0]       digit;
    logic [WIDTH+3:0] entry;
    logic step, at_bound, hit, saturate;

    // Decode a valid UART byte into command and digit strobes
    always_comb begin
        cmd_m     = rx_done && (rx_data == "M" || rx_data == "m");
        cmd_u     = rx_done && (rx_data == "U" || rx_data == "u");
        cmd_d     = rx_done && (rx_data == "D" || rx_data == "d");
        cmd_r     = rx_done && (rx_data == "R" || rx_data == "r");
        cmd_s     = rx_done && (rx_data == "S" || rx_data == "s");
        cmd_c     = rx_done && (rx_data == "C" || rx_data == "c");
        cmd_l     = rx_done && (rx_data == "L" || rx_data == "l");
        cmd_digit = rx_done && (rx_data >= "0") && (rx_data <= "9");
        digit     = rx_data[3:0];
        entry     = ({4'b0000, preset} << 3) + ({4'b0000, preset} << 1)
                  + {{WIDTH{1'b0}}, digit};
    end

    // Step strobe and bound detection for the current direction
    always_comb begin
        step     = (run_q == ST_RUN) && (presc == DIV_LAST);
        at_bound = (mode_q == M_DOWN) ? (count == '0) : (count == MAX_W);
        hit      = step && at_bound;
        saturate = hit && (WRAP == 0);
    end

    // Mode next state: explicit up/down beats any toggle request
    always_comb begin
        mode_d = mode_q;
        if (cmd_u)
            mode_d = M_UP;
        else if (cmd_d)
            mode_d = M_DOWN;
        else if (btn_mode || cmd_m)
            mode_d = ~mode_q;
    end

    // Run next state: UART commands are checked before buttons
    always_comb begin
        run_d = run_q;
        case (run_q)
            ST_STOP: begin
                if (cmd_r)
                    run_d = ST_RUN;
                else if (cmd_c)
                    run_d = ST_CLEAR;
                else if (cmd_l)
                    run_d = ST_LOAD;
                else if (btn_run_stop)
                    run_d = ST_RUN;
                else if (btn_clear)
                    run_d = ST_CLEAR;
            end
            ST_RUN: begin
                if (cmd_s || btn_run_stop || saturate)
                    run_d = ST_STOP;
            end
            default: run_d = ST_STOP;
        endcase
    end

    // Count next value: clear/load states, otherwise step in the current direction
    always_comb begin
        count_d = count;
        case (run_q)
            ST_CLEAR: count_d = '0;
            ST_LOAD:  count_d = preset;
            default: begin
                if (step) begin
                    if (hit) begin
                        if (WRAP != 0)
                            count_d = (mode_q == M_DOWN) ? MAX_W : '0;
                    end else if (mode_q == M_DOWN) begin
                        count_d = count - WIDTH'(1);
                    end else begin
                        count_d = count + WIDTH'(1);
                    end
                end
            end
        endcase
    end

    // Preset next value: load consumes it, digits accumulate or restart entry
    always_comb begin
        preset_d = preset;
        if (run_q == ST_LOAD)
            preset_d = '0;
        else if (cmd_digit)
            preset_d = (entry <= MAX_EXT) ? entry[WIDTH-1:0] : WIDTH'(digit);
    end

    // State, counter, preset and terminal-count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= M_UP;
            run_q  <= ST_STOP;
            count  <= '0;
            preset <= '0;
            tc     <= 1'b0;
        end else begin
            mode_q <= mode_d;
            run_q  <= run_d;
            count  <= count_d;
            preset <= preset_d;
            tc     <= hit;
        end
    end

    // Prescaler runs only in RUN, holds in STOP, zeroed by CLEAR/LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else begin
            case (run_q)
                ST_RUN:   presc <= step ? '0 : presc + PW'(1);
                ST_CLEAR,
                ST_LOAD:  presc <= '0;
                default:  presc <= presc;
            endcase
        end
    end

    // Output decode of the current FSM states
    always_comb begin
        mode     = mode_q[0];
        led_mode = (mode_q == M_DOWN) ? 2'b10 : 2'b01;
        case (run_q)
            ST_STOP: led_run_stop = 2'b01;
            ST_RUN:  led_run_stop = 2'b10;
            default: led_run_stop = 2'b00;
        endcase
    end

endmodule
